// File: rtl/alu_arbiter.sv
// alu_arbiter: two valid/ready requesters share one combinational alu; operands, result and flags are registered.
// Optional macro ALU_ARB_FIXED_PRIO_EN: fixed priority (requester 0 wins contention), no last-grant pointer.

package alu_ops;
    typedef enum logic [3:0] {
        OP_ADD      = 4'd0,
        OP_SUB      = 4'd1,
        OP_AND      = 4'd2,
        OP_OR       = 4'd3,
        OP_XOR      = 4'd4,
        OP_NOT      = 4'd5,
        OP_LL_SHIFT = 4'd6,
        OP_LR_SHIFT = 4'd7,
        OP_AR_SHIFT = 4'd8
    } alu_op_e;
endpackage

module alu #(
    parameter int WIDTH = 4
) (
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] y,
    output logic             cout,
    output logic             overflow,
    output logic             negative,
    output logic             zero
);
    import alu_ops::*;

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum;

    // SUB is a + ~b + cin, so cin acts as the inverted borrow.
    always_comb begin
        b_eff    = (op == OP_SUB) ? ~b : b;
        sum      = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        y        = '0;
        cout     = 1'b0;
        overflow = 1'b0;
        case (op)
            OP_ADD, OP_SUB: begin
                y        = sum[WIDTH-1:0];
                cout     = sum[WIDTH];
                overflow = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:      y = a & b;
            OP_OR:       y = a | b;
            OP_XOR:      y = a ^ b;
            OP_NOT:      y = ~a;
            OP_LL_SHIFT: y = a << b;
            OP_LR_SHIFT: y = a >> b;
            OP_AR_SHIFT: y = $signed(a) >>> b;
            default:     y = '0;
        endcase
    end

    assign negative = y[WIDTH-1];
    assign zero     = (y == '0);
endmodule

module alu_arbiter #(
    parameter int WIDTH = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [1:0]         req_valid,
    output logic [1:0]         req_ready,
    input  logic [7:0]         req_opcode,
    input  logic [2*WIDTH-1:0] req_a,
    input  logic [2*WIDTH-1:0] req_b,
    input  logic [1:0]         req_cin,
    output logic [1:0]         rsp_valid,
    input  logic [1:0]         rsp_ready,
    output logic [WIDTH-1:0]   rsp_y,
    output logic [3:0]         rsp_flags,
    output logic               busy
);
    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

    state_e           state_q;
    logic             gnt_q;
    logic [3:0]       op_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             cin_q;
    logic [WIDTH-1:0] y_q;
    logic [3:0]       flags_q;
    logic             gnt_d;

    logic [3:0]       op_arr [2];
    logic [WIDTH-1:0] a_arr  [2];
    logic [WIDTH-1:0] b_arr  [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_unpack
            assign op_arr[gi] = req_opcode[4*gi +: 4];
            assign a_arr[gi]  = req_a[gi*WIDTH +: WIDTH];
            assign b_arr[gi]  = req_b[gi*WIDTH +: WIDTH];
        end
    endgenerate

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign gnt_d = ~req_valid[0];
`else
    logic last_q;

    // On contention the requester that was not served last wins.
    always_comb begin
        gnt_d = req_valid[1];
        if (req_valid == 2'b11) begin
            gnt_d = ~last_q;
        end
    end
`endif

    logic [WIDTH-1:0] alu_y;
    logic             alu_cout;
    logic             alu_ovf;
    logic             alu_neg;
    logic             alu_zero;

    alu #(.WIDTH(WIDTH)) u_alu (
        .op       (op_q),
        .a        (a_q),
        .b        (b_q),
        .cin      (cin_q),
        .y        (alu_y),
        .cout     (alu_cout),
        .overflow (alu_ovf),
        .negative (alu_neg),
        .zero     (alu_zero)
    );

    assign req_ready = (state_q == S_IDLE && req_valid != 2'b00) ? (gnt_d ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid = (state_q == S_RESP) ? (gnt_q ? 2'b10 : 2'b01) : 2'b00;
    assign busy      = (state_q != S_IDLE);
    assign rsp_y     = y_q;
    assign rsp_flags = flags_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt_q   <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            cin_q   <= 1'b0;
            y_q     <= '0;
            flags_q <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
            last_q  <= 1'b1;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (req_valid != 2'b00) begin
                        gnt_q   <= gnt_d;
                        op_q    <= op_arr[gnt_d];
                        a_q     <= a_arr[gnt_d];
                        b_q     <= b_arr[gnt_d];
                        cin_q   <= req_cin[gnt_d];
                        state_q <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    y_q     <= alu_y;
                    flags_q <= {alu_cout, alu_ovf, alu_neg, alu_zero};
                    state_q <= S_RESP;
                end
                S_RESP: begin
                    if (rsp_ready[gnt_q]) begin
`ifndef ALU_ARB_FIXED_PRIO_EN
                        last_q <= gnt_q;
`endif
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end
endmodule
